// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: opcodes, branch funct3 codes, write-back selects, sequencer states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BTYPE    = 7'b1100011;
  localparam logic [6:0] OPC_LOADS    = 7'b0000011;
  localparam logic [6:0] OPC_STORES   = 7'b0100011;
  localparam logic [6:0] OPC_ARITHM_I = 7'b0010011;
  localparam logic [6:0] OPC_ARITHM_R = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC4  = 2'd1,
    WB_IMM  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_e;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus: request held with a stable address until the memory acknowledges.
interface instr_sequencer_if;
  import riscv_pkg::*;

  logic            IMEM_REQ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_ACK;
  logic [XLEN-1:0] IMEM_RDATA;

  modport master (output IMEM_REQ, output IMEM_ADDR, input IMEM_ACK, input IMEM_RDATA);
  modport slave  (input IMEM_REQ, input IMEM_ADDR, output IMEM_ACK, output IMEM_RDATA);
endinterface

// File: rtl/instr_sequencer_branch_eval.sv
// Branch condition from funct3 and ALU flags of a rs1-rs2 subtraction; purely combinational.
module branch_eval
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       z_i,
  input  logic       n_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = z_i;
      F3_BNE:  taken_o = ~z_i;
      F3_BLT:  taken_o = n_i ^ v_i;
      F3_BGE:  taken_o = ~(n_i ^ v_i);
      // C set means no borrow, i.e. rs1 >= rs2 unsigned
      F3_BLTU: taken_o = ~c_i;
      F3_BGEU: taken_o = c_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// RV32I multi-cycle sequencer: FETCH (waits for ACK) -> EXEC -> WB, three cycles minimum per instruction.
// Fetch stalls indefinitely on a missing ACK; illegal encodings or misaligned targets halt until reset.
module instr_sequencer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                RUN,
  instr_sequencer_if.master   imem,
  output logic [XLEN-1:0]     INSTR,
  input  logic [XLEN-1:0]     IMM,
  input  logic [XLEN-1:0]     D,
  input  logic                Z,
  input  logic                N,
  input  logic                C,
  input  logic                V,
  output logic                WE,
  output logic [1:0]          WB_SEL,
  output logic [XLEN-1:0]     PC,
  output logic                HALT,
  output logic [31:0]         RETIRED
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q, npc_q, instr_q;
  logic            we_q, req_q, halt_q;
  wb_sel_e         wb_sel_q;
  logic [31:0]     ret_q;

  logic [6:0]      opc;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic            br_taken, br_illegal;
  logic [XLEN-1:0] pc4, npc_d;
  logic            illegal_d, wr_d;
  wb_sel_e         sel_d;

  assign opc = instr_q[6:0];
  assign rd  = instr_q[11:7];
  assign f3  = instr_q[14:12];
  assign pc4 = pc_q + XLEN'(4);

  branch_eval u_branch_eval (
    .funct3_i  (f3),
    .z_i       (Z),
    .n_i       (N),
    .c_i       (C),
    .v_i       (V),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  always_comb begin
    npc_d     = pc4;
    illegal_d = 1'b0;
    wr_d      = 1'b0;
    sel_d     = WB_ALU;
    case (opc)
      OPC_ARITHM_I, OPC_ARITHM_R, OPC_AUIPC: wr_d = 1'b1;
      OPC_LUI: begin
        wr_d  = 1'b1;
        sel_d = WB_IMM;
      end
      OPC_JAL: begin
        npc_d = pc_q + IMM;
        wr_d  = 1'b1;
        sel_d = WB_PC4;
      end
      OPC_JALR: begin
        npc_d = D & ~XLEN'(1);
        wr_d  = 1'b1;
        sel_d = WB_PC4;
      end
      OPC_BTYPE: begin
        if (br_illegal)    illegal_d = 1'b1;
        else if (br_taken) npc_d     = pc_q + IMM;
      end
      OPC_LOADS, OPC_STORES: illegal_d = 1'b1;
      default:               illegal_d = 1'b1;
    endcase
    if (npc_d[1:0] != 2'b00) illegal_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC;
      instr_q  <= NOP;
      we_q     <= 1'b0;
      wb_sel_q <= WB_ALU;
      req_q    <= 1'b0;
      halt_q   <= 1'b0;
      ret_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (RUN) begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: if (imem.IMEM_ACK) begin
          instr_q <= imem.IMEM_RDATA;
          req_q   <= 1'b0;
          state_q <= S_EXEC;
        end
        // flags, D and IMM are captured here, at the end of the settle cycle
        S_EXEC: if (illegal_d) begin
          state_q <= S_HALTED;
          halt_q  <= 1'b1;
        end else begin
          state_q  <= S_WB;
          npc_q    <= npc_d;
          we_q     <= wr_d && (rd != 5'd0);
          wb_sel_q <= sel_d;
        end
        S_WB: begin
          pc_q  <= npc_q;
          ret_q <= ret_q + 32'd1;
          we_q  <= 1'b0;
          req_q <= RUN;
          state_q <= RUN ? S_FETCH : S_IDLE;
        end
        S_HALTED: begin
        end
        default: begin
          state_q <= S_HALTED;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  assign imem.IMEM_REQ  = req_q;
  assign imem.IMEM_ADDR = pc_q;
  assign INSTR   = instr_q;
  assign WE      = we_q;
  assign WB_SEL  = wb_sel_q;
  assign PC      = pc_q;
  assign HALT    = halt_q;
  assign RETIRED = ret_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM that drives the RV32I datapath (register file, immediate generator, ALU with Z/N/C/V flags). Fetches instructions over a req/ack instruction-memory bus, presents the latched word on INSTR, and issues one register-file write per retiring instruction. Owns the program counter, evaluates branches and jumps from datapath flags and results, and halts on unsupported encodings. Replaces hand-driven INSTR stimulus as the datapath's instruction source.

## Interface
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PC value after reset
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- RUN  in  1  level; 1 = execute, 0 = stop after current instruction
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  XLEN  fetch address (= PC)
- IMEM_ACK  in  1  fetch data valid
- IMEM_RDATA  in  XLEN  fetched word
- INSTR  out  XLEN  latched instruction to datapath decode
- IMM  in  XLEN  decoded immediate from datapath
- D  in  XLEN  ALU result
- Z, N, C, V  in  1 each  ALU flags; C=1 means rs1 >= rs2 unsigned on SUB
- WE  out  1  register-file write enable
- WB_SEL  out  2  write-back source: 0 ALU, 1 PC+4, 2 IMM, 3 reserved
- PC  out  XLEN  current program counter
- HALT  out  1  sticky fault flag
- RETIRED  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, EXEC, WB, HALTED.
- IDLE: IMEM_REQ=0. RUN=1 -> FETCH.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC held stable until IMEM_ACK. On ACK, INSTR<=IMEM_RDATA -> EXEC. ACK while not in FETCH is ignored.
- EXEC: one cycle for the datapath to settle. Decodes opcode, computes next PC:
  - ARITHM_I/ARITHM_R/LUI/AUIPC: PC+4. WB_SEL: ALU, except LUI=IMM.
  - JAL: PC+IMM, WB_SEL=PC+4. JALR: D & ~1, WB_SEL=PC+4.
  - BTYPE: taken -> PC+IMM, else PC+4; no write. funct3 000 Z, 001 !Z, 100 N^V, 101 !(N^V), 110 !C, 111 C; 010/011 illegal.
  - LOADS, STORES, any other opcode: illegal.
  - Illegal, or next-PC[1:0]!=0 -> HALTED (PC unchanged, no write, not retired).
- WB: WE=1 for one cycle if opcode writes rd and rd!=0. PC<=next PC, RETIRED+=1 (wraps 0xFFFF_FFFF -> 0). Then FETCH if RUN, else IDLE.
- HALTED: HALT=1, all strobes 0. Exit only via reset.
- RUN deassert mid-instruction: current instruction completes through WB, then IDLE.

## Timing
- Reset values: PC=RESET_PC, INSTR=32'h0000_0013 (NOP), WE=0, WB_SEL=0, IMEM_REQ=0, IMEM_ADDR=RESET_PC, HALT=0, RETIRED=0, state IDLE.
- Reset mid-fetch: IMEM_REQ drops asynchronously; a subsequent late ACK is ignored.
- Minimum 3 cycles per instruction (ACK in first FETCH cycle); each wait cycle adds one.
- WE and WB_SEL are registered; WE high in WB only. INSTR stable from EXEC through WB.
- PC updates on the WB->next edge; IMEM_ADDR for the next FETCH is the new PC.
- Flags and D sampled at end of EXEC; IMM and D must be valid by then.

## Structure
- Shared package riscv_pkg: opcode constants (LUI, AUIPC, JAL, JALR, BTYPE, LOADS, STORES, ARITHM_I, ARITHM_R), branch funct3 codes, WB_SEL encodings, state enum, NOP constant.
- Sub-module branch_eval: combinational funct3 + Z/N/C/V -> taken, illegal.
- FSM, PC register and RETIRED counter live in instr_sequencer.

## Test plan
- Reset then RUN=1, memory ACK same cycle, ADDI x1,x0,54 at 0x0 -> IMEM_ADDR=0x0, WE=1 on cycle 3, WB_SEL=0, PC=0x4, RETIRED=1.
- ACK delayed 4 cycles -> IMEM_REQ and IMEM_ADDR held for 4 cycles, WE on cycle 7, no early INSTR change.
- BEQ with Z=1, IMM=-8 at PC=0x10 -> PC=0x08, WE=0. Same with Z=0 -> PC=0x14. BLTU with C=0 -> taken.
- JAL x1,+0x20 at PC=0x40 -> WE=1, WB_SEL=1, PC=0x60. JALR with D=0x101 -> PC=0x100. D=0x102 -> HALT=1, PC unchanged.
- LOADS opcode (0000011) -> HALT=1, WE never asserted, RETIRED unchanged. Held until RST_N low.
- RUN dropped during FETCH wait -> instruction still retires, then IDLE with IMEM_REQ=0. RST_N pulsed mid-FETCH -> all outputs at reset values immediately.
